// File: rtl/rv32i_types.sv
// Shared RV32I pipeline types: branch-prediction tracking slot and PC constants.
package rv32i_types;

  localparam int unsigned XLEN = 32;
  localparam logic [XLEN-1:0] PC_STEP = 32'd4;

  typedef struct packed {
    logic            valid;
    logic [XLEN-1:0] pc;
    logic            p_tnt;
    logic [XLEN-1:0] p_target;
  } bp_slot_t;

endpackage

// File: rtl/bp_slot_reg.sv
// One prediction-tracking slot register with synchronous reset, clear, load and hold.
module bp_slot_reg
  import rv32i_types::*;
(
  input  logic     clk,
  input  logic     rst,
  input  logic     load,
  input  logic     clear,
  input  bp_slot_t d,
  output bp_slot_t q
);

  // Clear beats load so a flush cannot be overridden by the incoming fetch.
  always_ff @(posedge clk) begin
    if (rst) begin
      q <= '0;
    end else if (clear) begin
      q <= '0;
    end else if (load) begin
      q <= d;
    end
  end

endmodule

// File: rtl/bp_resolve_unit.sv
// Tracks fetch-time predictions through ID/EX, resolves them against EX outcomes,
// drives predictor update, fetch redirect and saturating branch statistics.
module bp_resolve_unit
  import rv32i_types::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall,
  input  logic [31:0]      if_pc,
  input  logic             if_p_tnt,
  input  logic [31:0]      if_p_target,
  input  logic             ex_is_br,
  input  logic             ex_br_taken,
  input  logic [31:0]      ex_br_target,
  output logic             update,
  output logic             prev_mispredict,
  output logic [31:0]      ex_pc_out,
  output logic             redirect,
  output logic [31:0]      redirect_pc,
  output logic [CNT_W-1:0] br_count,
  output logic [CNT_W-1:0] mp_count
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  bp_slot_t id_d;
  bp_slot_t id_q;
  bp_slot_t ex_q;
  logic     slot_load;
  logic     slot_clear;
  logic     resolve;
  logic     mis;

  assign id_d = '{valid: 1'b1, pc: if_pc, p_tnt: if_p_tnt, p_target: if_p_target};

  // Stall holds both slots; a redirect flushes ID and the wrong-path IF instruction.
  assign slot_load  = !stall;
  assign slot_clear = !stall && redirect;

  bp_slot_reg u_id_slot (
    .clk   (clk),
    .rst   (rst),
    .load  (slot_load),
    .clear (slot_clear),
    .d     (id_d),
    .q     (id_q)
  );

  bp_slot_reg u_ex_slot (
    .clk   (clk),
    .rst   (rst),
    .load  (slot_load),
    .clear (slot_clear),
    .d     (id_q),
    .q     (ex_q)
  );

  // Resolve only on the unstalled cycle, so a branch held in EX pulses once.
  always_comb begin
    resolve         = !stall && ex_q.valid && ex_is_br;
    mis             = (ex_q.p_tnt != ex_br_taken) ||
                      (ex_br_taken && ex_q.p_tnt && (ex_q.p_target != ex_br_target));
    update          = resolve;
    prev_mispredict = resolve && mis;
    redirect        = prev_mispredict;
    redirect_pc     = '0;
    if (redirect) begin
      redirect_pc = ex_br_taken ? ex_br_target : (ex_q.pc + PC_STEP);
    end
    ex_pc_out = ex_q.valid ? ex_q.pc : '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      br_count <= '0;
      mp_count <= '0;
    end else begin
      if (resolve && (br_count != CNT_MAX)) begin
        br_count <= br_count + 1'b1;
      end
      if (prev_mispredict && (mp_count != CNT_MAX)) begin
        mp_count <= mp_count + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_bp_resolve_unit.sv
// Directed and random checks of bp_resolve_unit against a pipeline-level reference model.
module tb_bp_resolve_unit;

  localparam int CNT_W = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic             stall;
  logic [31:0]      if_pc;
  logic             if_p_tnt;
  logic [31:0]      if_p_target;
  logic             ex_is_br;
  logic             ex_br_taken;
  logic [31:0]      ex_br_target;
  logic             update;
  logic             prev_mispredict;
  logic [31:0]      ex_pc_out;
  logic             redirect;
  logic [31:0]      redirect_pc;
  logic [CNT_W-1:0] br_count;
  logic [CNT_W-1:0] mp_count;

  bp_resolve_unit #(.CNT_W(CNT_W)) dut (
    .clk             (clk),
    .rst             (rst),
    .stall           (stall),
    .if_pc           (if_pc),
    .if_p_tnt        (if_p_tnt),
    .if_p_target     (if_p_target),
    .ex_is_br        (ex_is_br),
    .ex_br_taken     (ex_br_taken),
    .ex_br_target    (ex_br_target),
    .update          (update),
    .prev_mispredict (prev_mispredict),
    .ex_pc_out       (ex_pc_out),
    .redirect        (redirect),
    .redirect_pc     (redirect_pc),
    .br_count        (br_count),
    .mp_count        (mp_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit        v;
    bit [31:0] pc;
    bit        pt;
    bit [31:0] tg;
  } mslot_t;

  mslot_t      m_id;
  mslot_t      m_ex;
  longint      n_br;
  longint      n_mp;
  int          n_checks = 0;
  int          n_err = 0;
  bit          e_res;
  bit          e_mp;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic bit [31:0] sat(input longint n);
    longint mx = (longint'(1) << CNT_W) - 1;
    return (n > mx) ? 32'(mx) : 32'(n);
  endfunction

  task automatic drive(input bit r, input bit s, input bit [31:0] pc, input bit pt,
                       input bit [31:0] tg, input bit isbr, input bit tk, input bit [31:0] bt);
    rst = r; stall = s; if_pc = pc; if_p_tnt = pt; if_p_target = tg;
    ex_is_br = isbr; ex_br_taken = tk; ex_br_target = bt;
  endtask

  // Mid-cycle comparison of every output against the model's view of the pipeline.
  task automatic eval();
    bit        mis;
    bit [31:0] rpc;
    bit [31:0] expc;
    #4;
    e_res = !stall && m_ex.v && ex_is_br;
    mis   = (m_ex.pt != ex_br_taken) || (ex_br_taken && m_ex.pt && (m_ex.tg != ex_br_target));
    e_mp  = e_res && mis;
    rpc   = 32'd0;
    if (e_mp) rpc = ex_br_taken ? ex_br_target : (m_ex.pc + 32'd4);
    expc  = m_ex.v ? m_ex.pc : 32'd0;
    check("update", 32'(update), 32'(e_res));
    check("prev_mispredict", 32'(prev_mispredict), 32'(e_mp));
    check("redirect", 32'(redirect), 32'(e_mp));
    check("redirect_pc", redirect_pc, rpc);
    check("ex_pc_out", ex_pc_out, expc);
    check("br_count", 32'(br_count), sat(n_br));
    check("mp_count", 32'(mp_count), sat(n_mp));
  endtask

  task automatic adv();
    @(posedge clk);
    if (rst) begin
      m_id = '{default: 0};
      m_ex = '{default: 0};
      n_br = 0;
      n_mp = 0;
    end else if (!stall) begin
      n_br += longint'(e_res);
      n_mp += longint'(e_mp);
      if (e_mp) begin
        m_id = '{default: 0};
        m_ex = '{default: 0};
      end else begin
        m_ex = m_id;
        m_id = '{v: 1'b1, pc: if_pc, pt: if_p_tnt, tg: if_p_target};
      end
    end
    #1;
  endtask

  task automatic step();
    eval();
    adv();
  endtask

  initial begin
    bit [31:0] bt;
    m_id = '{default: 0};
    m_ex = '{default: 0};
    n_br = 0;
    n_mp = 0;
    drive(1, 0, 0, 0, 0, 0, 0, 0);
    @(posedge clk); #1;
    drive(1, 1, 32'h55, 1, 32'h77, 1, 1, 32'h99);
    step();
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    eval();
    check("post_rst_update", 32'(update), 0);
    check("post_rst_ex_pc", ex_pc_out, 0);
    check("post_rst_rpc", redirect_pc, 0);
    adv();

    // Correctly predicted not-taken branch.
    drive(0, 0, 32'h100, 0, 0, 0, 0, 0); step();
    drive(0, 0, 32'h104, 0, 0, 0, 0, 0); step();
    drive(0, 0, 32'h108, 0, 0, 1, 0, 0); eval();
    check("nt_update", 32'(update), 1);
    check("nt_mispredict", 32'(prev_mispredict), 0);
    check("nt_redirect", 32'(redirect), 0);
    adv();
    check("nt_br_count", 32'(br_count), 1);

    // Direction miss, then a branch flag on the flushed slot must be ignored.
    drive(0, 0, 32'h200, 0, 0, 0, 0, 0); step();
    drive(0, 0, 32'h204, 0, 0, 0, 0, 0); step();
    drive(0, 0, 32'h208, 0, 0, 1, 1, 32'h240); eval();
    check("dir_redirect", 32'(redirect), 1);
    check("dir_rpc", redirect_pc, 32'h240);
    adv();
    check("dir_mp_count", 32'(mp_count), 1);
    drive(0, 0, 32'h240, 0, 0, 1, 1, 32'h888); eval();
    check("flush_ex_pc", ex_pc_out, 0);
    check("flush_no_update", 32'(update), 0);
    adv();
    drive(0, 0, 32'h244, 0, 0, 0, 0, 0); eval();
    check("flush_ex_pc2", ex_pc_out, 0);
    adv();

    // Target miss.
    drive(0, 0, 32'h280, 1, 32'h300, 0, 0, 0); step();
    drive(0, 0, 32'h300, 0, 0, 0, 0, 0); step();
    drive(0, 0, 32'h304, 0, 0, 1, 1, 32'h304); eval();
    check("tgt_mispredict", 32'(prev_mispredict), 1);
    check("tgt_rpc", redirect_pc, 32'h304);
    adv();

    // Mispredicted branch held in EX by a 3-cycle stall.
    drive(0, 0, 32'h400, 0, 0, 0, 0, 0); step();
    drive(0, 0, 32'h404, 0, 0, 0, 0, 0); step();
    for (int i = 0; i < 3; i++) begin
      drive(0, 1, 32'h408, 0, 0, 1, 1, 32'h500); eval();
      check("stall_no_update", 32'(update), 0);
      check("stall_no_redirect", 32'(redirect), 0);
      adv();
    end
    drive(0, 0, 32'h408, 0, 0, 1, 1, 32'h500); eval();
    check("stall_release_update", 32'(update), 1);
    check("stall_release_rpc", redirect_pc, 32'h500);
    adv();
    drive(0, 0, 32'h500, 0, 0, 1, 1, 32'h500); eval();
    check("stall_single_pulse", 32'(update), 0);
    adv();

    // Fall-through wraps past the top of the address space.
    drive(0, 0, 32'hFFFF_FFFC, 1, 32'h1000, 0, 0, 0); step();
    drive(0, 0, 32'h1000, 0, 0, 0, 0, 0); step();
    drive(0, 0, 32'h1004, 0, 0, 1, 0, 0); eval();
    check("wrap_redirect", 32'(redirect), 1);
    check("wrap_rpc", redirect_pc, 32'h0);
    adv();

    // Random traffic against the model.
    drive(1, 0, 0, 0, 0, 0, 0, 0); step();
    for (int i = 0; i < 400; i++) begin
      bt = ($urandom_range(0, 1) == 1) ? m_ex.tg : ($urandom() & 32'hFFFF_FFFC);
      drive(($urandom_range(0, 63) == 0), ($urandom_range(0, 3) == 0),
            $urandom() & 32'hFFFF_FFFC, 1'($urandom()), $urandom() & 32'hFFFF_FFFC,
            1'($urandom()), 1'($urandom()), bt);
      step();
    end

    // Counter saturation with CNT_W=4.
    drive(1, 0, 0, 0, 0, 0, 0, 0); step();
    for (int i = 0; i < 200 && n_mp < 20; i++) begin
      drive(0, 0, 32'(i * 4), 0, 0, 1, 1, 32'h800);
      step();
    end
    drive(0, 0, 32'h700, 0, 0, 0, 0, 0); eval();
    check("sat_mp_count", 32'(mp_count), 15);
    check("sat_br_count", 32'(br_count), 15);
    adv();

    // Reset during a stalled branch discards it.
    drive(0, 0, 32'h900, 0, 0, 0, 0, 0); step();
    drive(0, 0, 32'h904, 0, 0, 0, 0, 0); step();
    drive(0, 1, 32'h908, 0, 0, 1, 1, 32'hA00); step();
    drive(1, 1, 32'h908, 0, 0, 1, 1, 32'hA00); step();
    drive(0, 0, 32'h908, 0, 0, 1, 1, 32'hA00); eval();
    check("rst_stall_update", 32'(update), 0);
    check("rst_stall_br_count", 32'(br_count), 0);
    check("rst_stall_mp_count", 32'(mp_count), 0);
    check("rst_stall_ex_pc", ex_pc_out, 0);
    adv();
    drive(0, 0, 32'h90C, 0, 0, 1, 1, 32'hA00); eval();
    check("rst_stall_update2", 32'(update), 0);
    adv();

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
